beat_sequencer: RTL and testbench
=================================

# beat_sequencer

Record/playback controller for the tone datapath. In RECORD it samples the live keyboard ASCII code at a fixed tick rate into an internal slot memory. In PLAY it replays those slots in order, driving `ascii` and `is_loading` of the saved-buzzer rate divider (`rate_divider_for_load`). It sits between the PS/2 keyboard decoder and the speaker rate dividers, and is the only block that sequences the saved-buzzer tone path.

## Interface
Parameters:
- `TICK_CYCLES`, default 3125000: clk cycles per slot (1/16 s at 50 MHz); must be ≥ 2.
- `DEPTH`, default 64: number of slots in the note memory.
- `ADDR_W`, default 6: slot address width; `2**ADDR_W` ≥ `DEPTH`.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  synchronous, active-high reset.
- `record_req`  in  1  single-cycle pulse: start recording (honoured only in IDLE).
- `play_req`  in  1  single-cycle pulse: start playback (honoured only in IDLE with `length` ≠ 0).
- `stop_req`  in  1  single-cycle pulse: end RECORD or PLAY.
- `ascii_in`  in  7  live key code; 0 means no key held.
- `ascii_out`  out  7  replayed key code to the rate divider.
- `is_loading`  out  1  playback tone enable to the rate divider.
- `recording`  out  1  high while in RECORD.
- `playing`  out  1  high while in PLAY.
- `slot_addr`  out  ADDR_W  current slot index.
- `length`  out  ADDR_W+1  number of valid recorded slots (0..DEPTH).

## Operation
- FSM states are IDLE, RECORD and PLAY. Reset enters IDLE.
- **Reset values:** `ascii_out`=0, `is_loading`=0, `recording`=0, `playing`=0, `slot_addr`=0, `length`=0, tick counter=0. Memory contents are not cleared, but `length`=0 makes them unreachable.
- **IDLE request priority:** `stop_req` > `record_req` > `play_req`.
  - `stop_req` in IDLE is a no-op and blocks the other requests that cycle.
  - `play_req` with `length`=0 is ignored.
- **RECORD entry:** `slot_addr`←0, tick←0, `length`←0, `recording`←1.
- **RECORD ticks:** when tick = `TICK_CYCLES`-1, the block writes `mem[slot_addr]`←`ascii_in`, increments `slot_addr`, and sets tick←0. Otherwise tick increments.
- **RECORD exit by stop:** `stop_req` sets `length`←`slot_addr` and returns to IDLE. A sample due in the same cycle as `stop_req` is NOT written.
- **RECORD exit on full:** the write to slot `DEPTH`-1 sets `length`←`DEPTH` and returns to IDLE in the same edge.
- **RECORD ignores** `play_req` and repeated `record_req`.
- **PLAY entry:** `slot_addr`←0, tick←0, `ascii_out`←`mem[0]`, `playing`←1.
- **PLAY ticks:** when tick = `TICK_CYCLES`-1:
  - If `slot_addr`+1 < `length`: `slot_addr`++ and `ascii_out`←`mem[slot_addr+1]`.
  - Otherwise: go to IDLE with `ascii_out`←0.
- **PLAY exit by stop:** `stop_req` returns to IDLE with `ascii_out`←0. PLAY ignores `record_req` and `play_req`.
- **Tone enable:** `is_loading` is high only when `playing`=1 and `ascii_out`≠0. A recorded silent slot therefore mutes the speaker, so the divider's default tone is never heard.
- **Leaving RECORD or PLAY:** `slot_addr`←0 and tick←0.
- **Arithmetic:**
  - The tick counter is `$clog2(TICK_CYCLES)` bits wide and never exceeds `TICK_CYCLES`-1.
  - `length` is unsigned and is compared to `slot_addr`+1 at ADDR_W+1 bits, so there is no wrap when `DEPTH`=`2**ADDR_W`.
- **Reset mid-RECORD or mid-PLAY** aborts immediately to the reset values. A partial recording is discarded.

## Timing
- All outputs are registered. `recording`, `playing`, `ascii_out` and `is_loading` change on the edge that accepts the request (edge E0).
- **Record sampling:** slot k (k=0..) captures `ascii_in` as sampled at edge E0+(k+1)·`TICK_CYCLES`.
- **Playback:** `ascii_out`=`mem[j]` holds from edge E0+j·`TICK_CYCLES` until the next slot edge.
- **Playback end:** at edge E0+`length`·`TICK_CYCLES`, `playing`=0, `is_loading`=0 and `ascii_out`=0.
- **Stop latency:** 1 edge. Outputs are inactive on the edge that samples `stop_req`.
- **Back-to-back:** a new request is accepted on any cycle after return to IDLE. A request on the same edge as an automatic return is ignored.
- Memory is a register array written on the tick edge and read into `ascii_out` on the same-class edge. There is no additional read latency visible at the ports.

## Test plan
All scenarios use `TICK_CYCLES`=4, `DEPTH`=8, `ADDR_W`=3.
- **Record/stop:** pulse `record_req`, hold `ascii_in`=65 for 8 cycles, then 0 for 4, then pulse `stop_req` -> `length`=3, mem = {65,65,0}, `recording` low 1 edge after stop.
- **Play back that recording:** pulse `play_req` -> `ascii_out`=65 with `is_loading`=1 for 8 cycles, then `ascii_out`=0 with `is_loading`=0 for 4 cycles, then `playing`=0 exactly 12 cycles after accept.
- **Record overflow:** record with `ascii_in`=87 for 40 cycles -> `length`=8 and auto-IDLE at edge E0+32. Later writes must not occur (`recording`=0).
- **Priority and ignores:**
  - `record_req`+`play_req` in the same IDLE cycle -> RECORD.
  - `play_req` with `length`=0 -> stays IDLE, `playing`=0.
  - `record_req` during PLAY -> no effect.
- **Stop mid-play and tick-coincident stop:** stop at cycle 5 of PLAY -> `ascii_out`=0 next edge. `stop_req` coinciding with a record tick -> that sample is not stored.
- **Reset mid-operation:** assert `reset` during PLAY slot 2 -> next edge all outputs at reset values, `length`=0; a following `play_req` is ignored.

Source files
------------

// File: rtl/beat_sequencer.sv
// beat_sequencer: record/playback controller for the saved-buzzer tone path.
// RECORD samples the live key code once per tick into a slot memory. PLAY
// replays the recorded slots in order to the rate divider.
module beat_sequencer #(
  parameter int TICK_CYCLES = 3125000,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              record_req,
  input  logic              play_req,
  input  logic              stop_req,
  input  logic [6:0]        ascii_in,
  output logic [6:0]        ascii_out,
  output logic              is_loading,
  output logic              recording,
  output logic              playing,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [ADDR_W:0]   length
);

  localparam int TICK_W = $clog2(TICK_CYCLES);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [ADDR_W-1:0] SLOT_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] SLOT_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SLOT_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LEN_ZERO  = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LEN_FULL  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [TICK_W-1:0]   tick_r;
  logic [TICK_W-1:0]   tick_s;
  logic [ADDR_W-1:0]   slot_s;
  logic [ADDR_W:0]     length_s;
  logic [6:0]          ascii_s;
  logic                loading_s;
  logic                wr_en_s;
  logic [ADDR_W:0]     slot_inc_s;
  logic [6:0]          mem_r [DEPTH];

  // Next slot index at ADDR_W+1 bits so the compare against length cannot wrap.
  assign slot_inc_s = {1'b0, slot_addr} + LEN_ONE;

  // Next-state, next-output and memory write-enable decode.
  always_comb begin
    state_s  = state_r;
    tick_s   = tick_r;
    slot_s   = slot_addr;
    length_s = length;
    ascii_s  = ascii_out;
    wr_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (stop_req) begin
          // Stop in IDLE does nothing but masks the other requests.
          state_s = ST_IDLE;
        end else if (record_req) begin
          state_s  = ST_RECORD;
          slot_s   = SLOT_ZERO;
          tick_s   = TICK_ZERO;
          length_s = LEN_ZERO;
        end else if (play_req && (length != LEN_ZERO)) begin
          state_s = ST_PLAY;
          slot_s  = SLOT_ZERO;
          tick_s  = TICK_ZERO;
          ascii_s = mem_r[SLOT_ZERO];
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RECORD: begin
        if (stop_req) begin
          // A sample due on this same edge is dropped.
          state_s  = ST_IDLE;
          length_s = {1'b0, slot_addr};
          slot_s   = SLOT_ZERO;
          tick_s   = TICK_ZERO;
        end else if (tick_r == TICK_LAST) begin
          wr_en_s = 1'b1;
          tick_s  = TICK_ZERO;
          if (slot_addr == SLOT_LAST) begin
            state_s  = ST_IDLE;
            length_s = LEN_FULL;
            slot_s   = SLOT_ZERO;
          end else begin
            slot_s = slot_addr + SLOT_ONE;
          end
        end else begin
          tick_s = tick_r + TICK_ONE;
        end
      end
      ST_PLAY: begin
        if (stop_req) begin
          state_s = ST_IDLE;
          ascii_s = 7'd0;
          slot_s  = SLOT_ZERO;
          tick_s  = TICK_ZERO;
        end else if (tick_r == TICK_LAST) begin
          tick_s = TICK_ZERO;
          if (slot_inc_s < length) begin
            slot_s  = slot_inc_s[ADDR_W-1:0];
            ascii_s = mem_r[slot_inc_s[ADDR_W-1:0]];
          end else begin
            state_s = ST_IDLE;
            ascii_s = 7'd0;
            slot_s  = SLOT_ZERO;
          end
        end else begin
          tick_s = tick_r + TICK_ONE;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        slot_s   = SLOT_ZERO;
        tick_s   = TICK_ZERO;
        ascii_s  = 7'd0;
      end
    endcase
    // A silent slot mutes the divider instead of letting its default tone play.
    loading_s = (state_s == ST_PLAY) && (ascii_s != 7'd0);
  end

  // State, counter and registered output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      tick_r     <= TICK_ZERO;
      slot_addr  <= SLOT_ZERO;
      length     <= LEN_ZERO;
      ascii_out  <= 7'd0;
      is_loading <= 1'b0;
      recording  <= 1'b0;
      playing    <= 1'b0;
    end else begin
      state_r    <= state_s;
      tick_r     <= tick_s;
      slot_addr  <= slot_s;
      length     <= length_s;
      ascii_out  <= ascii_s;
      is_loading <= loading_s;
      recording  <= (state_s == ST_RECORD);
      playing    <= (state_s == ST_PLAY);
    end
  end

  // Slot memory write; contents survive reset and are hidden by length=0.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_r[slot_addr] <= ascii_in;
    end else begin
      mem_r[slot_addr] <= mem_r[slot_addr];
    end
  end

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed scoreboard bench for beat_sequencer (TICK_CYCLES=4, DEPTH=8, ADDR_W=3).
module tb_beat_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       record_req = 1'b0;
  logic       play_req = 1'b0;
  logic       stop_req = 1'b0;
  logic [6:0] ascii_in = 7'd0;
  logic [6:0] ascii_out;
  logic       is_loading;
  logic       recording;
  logic       playing;
  logic [2:0] slot_addr;
  logic [3:0] length;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [16:0] val;
  } exp_t;

  exp_t sb_q[$];

  beat_sequencer #(.TICK_CYCLES(4), .DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .record_req(record_req), .play_req(play_req),
    .stop_req(stop_req), .ascii_in(ascii_in), .ascii_out(ascii_out),
    .is_loading(is_loading), .recording(recording), .playing(playing),
    .slot_addr(slot_addr), .length(length)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] mk(input logic [6:0] asc, input logic ld,
                                     input logic rec, input logic ply,
                                     input logic [2:0] slot, input logic [3:0] len);
    return {asc, ld, rec, ply, slot, len};
  endfunction

  function automatic logic [16:0] idle(input logic [3:0] len);
    return mk(7'd0, 1'b0, 1'b0, 1'b0, 3'd0, len);
  endfunction

  // Push the expectation, drive one edge of requests, then pop and compare.
  task automatic step(input string tag, input logic r, input logic p, input logic s,
                      input logic [16:0] e);
    exp_t x;
    exp_t got;
    logic [16:0] obs;
    x.tag = tag;
    x.val = e;
    sb_q.push_back(x);
    record_req = r;
    play_req = p;
    stop_req = s;
    @(posedge clk);
    #1;
    record_req = 1'b0;
    play_req = 1'b0;
    stop_req = 1'b0;
    got = sb_q.pop_front();
    obs = {ascii_out, is_loading, recording, playing, slot_addr, length};
    checks++;
    assert (obs === got.val) else begin
      failures++;
      $error("FAIL %s observed{asc,ld,rec,ply,slot,len}=%0d,%0b,%0b,%0b,%0d,%0d expected=%0d,%0b,%0b,%0b,%0d,%0d",
             got.tag, obs[16:10], obs[9], obs[8], obs[7], obs[6:4], obs[3:0],
             got.val[16:10], got.val[9], got.val[8], got.val[7], got.val[6:4], got.val[3:0]);
    end
  endtask

  initial begin
    logic [2:0] sl;
    logic [6:0] a;
    // Reset state
    step("reset_a", 1'b0, 1'b0, 1'b0, idle(4'd0));
    step("reset_b", 1'b0, 1'b0, 1'b0, idle(4'd0));
    reset = 1'b0;
    step("idle_after_reset", 1'b0, 1'b0, 1'b0, idle(4'd0));

    // Record 65,65,0 then stop
    step("rec1_accept", 1'b1, 1'b0, 1'b0, mk(7'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0));
    ascii_in = 7'd65;
    for (int c = 1; c <= 12; c++) begin
      if (c == 9) ascii_in = 7'd0;
      sl = 3'(c / 4);
      step("rec1_run", 1'b0, 1'b0, 1'b0, mk(7'd0, 1'b0, 1'b1, 1'b0, sl, 4'd0));
    end
    step("rec1_stop", 1'b0, 1'b0, 1'b1, idle(4'd3));

    // Play it back
    step("play1_accept", 1'b0, 1'b1, 1'b0, mk(7'd65, 1'b1, 1'b0, 1'b1, 3'd0, 4'd3));
    for (int c = 1; c <= 12; c++) begin
      if (c < 12) begin
        sl = 3'(c / 4);
        a = (c < 8) ? 7'd65 : 7'd0;
        step("play1_run", 1'b0, 1'b0, 1'b0, mk(a, a != 7'd0, 1'b0, 1'b1, sl, 4'd3));
      end else begin
        step("play1_end", 1'b0, 1'b0, 1'b0, idle(4'd3));
      end
    end

    // Priority and ignored requests
    step("idle_stop_blocks", 1'b1, 1'b1, 1'b1, idle(4'd3));
    step("rec_over_play", 1'b1, 1'b1, 1'b0, mk(7'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0));
    step("rec_ignores_play", 1'b0, 1'b1, 1'b0, mk(7'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0));
    step("rec_stop_empty", 1'b0, 1'b0, 1'b1, idle(4'd0));
    step("play_len0_ignored", 1'b0, 1'b1, 1'b0, idle(4'd0));

    // Record overflow
    ascii_in = 7'd87;
    step("ovf_accept", 1'b1, 1'b0, 1'b0, mk(7'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0));
    for (int c = 1; c <= 40; c++) begin
      sl = 3'(c / 4);
      if (c < 32) step("ovf_run", 1'b0, 1'b0, 1'b0, mk(7'd0, 1'b0, 1'b1, 1'b0, sl, 4'd0));
      else        step("ovf_full", 1'b0, 1'b0, 1'b0, idle(4'd8));
    end
    ascii_in = 7'd0;

    // Full playback with ignored requests, request on auto-return edge ignored
    step("play8_accept", 1'b0, 1'b1, 1'b0, mk(7'd87, 1'b1, 1'b0, 1'b1, 3'd0, 4'd8));
    for (int c = 1; c <= 32; c++) begin
      sl = 3'(c / 4);
      if (c < 32) step("play8_run", c == 5, c == 6, 1'b0, mk(7'd87, 1'b1, 1'b0, 1'b1, sl, 4'd8));
      else        step("play8_end_req_ignored", 1'b0, 1'b1, 1'b0, idle(4'd8));
    end

    // Stop mid-play
    step("play_stop_accept", 1'b0, 1'b1, 1'b0, mk(7'd87, 1'b1, 1'b0, 1'b1, 3'd0, 4'd8));
    for (int c = 1; c <= 4; c++) begin
      sl = 3'(c / 4);
      step("play_stop_run", 1'b0, 1'b0, 1'b0, mk(7'd87, 1'b1, 1'b0, 1'b1, sl, 4'd8));
    end
    step("play_stop", 1'b0, 1'b0, 1'b1, idle(4'd8));

    // Reset during slot 2
    step("play_rst_accept", 1'b0, 1'b1, 1'b0, mk(7'd87, 1'b1, 1'b0, 1'b1, 3'd0, 4'd8));
    for (int c = 1; c <= 8; c++) begin
      sl = 3'(c / 4);
      step("play_rst_run", 1'b0, 1'b0, 1'b0, mk(7'd87, 1'b1, 1'b0, 1'b1, sl, 4'd8));
    end
    reset = 1'b1;
    step("mid_play_reset", 1'b0, 1'b0, 1'b0, idle(4'd0));
    reset = 1'b0;
    step("play_after_reset_ignored", 1'b0, 1'b1, 1'b0, idle(4'd0));

    // Stop coinciding with a record tick drops that sample
    ascii_in = 7'd11;
    step("tick_stop_accept", 1'b1, 1'b0, 1'b0, mk(7'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0));
    for (int c = 1; c <= 7; c++) begin
      if (c == 5) ascii_in = 7'd22;
      sl = 3'(c / 4);
      step("tick_stop_run", 1'b0, 1'b0, 1'b0, mk(7'd0, 1'b0, 1'b1, 1'b0, sl, 4'd0));
    end
    step("tick_stop", 1'b0, 1'b0, 1'b1, idle(4'd1));
    ascii_in = 7'd0;
    step("tick_play_accept", 1'b0, 1'b1, 1'b0, mk(7'd11, 1'b1, 1'b0, 1'b1, 3'd0, 4'd1));
    for (int c = 1; c <= 3; c++) begin
      step("tick_play_run", 1'b0, 1'b0, 1'b0, mk(7'd11, 1'b1, 1'b0, 1'b1, 3'd0, 4'd1));
    end
    step("tick_play_end", 1'b0, 1'b0, 1'b0, idle(4'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
